// File: rtl/ex_pkg.sv
// Shared execute-stage definitions.
//   EX_N       : default datapath width (matches the upstream adder)
//   ex_op_e    : result op codes (pass-through and set-conditions on A-B)
//   ex_state_e : result-stage control states
package ex_pkg;

    localparam int EX_N = 32;

    typedef enum logic [2:0] {
        OP_PASS_S = 3'b000,
        OP_PASS_U = 3'b001,
        OP_SEQ    = 3'b010,
        OP_SNE    = 3'b011,
        OP_SLT    = 3'b100,
        OP_SGE    = 3'b101,
        OP_SGT    = 3'b110,
        OP_SLE    = 3'b111
    } ex_op_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_TRAPPED = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_setcond.sv
// Combinational result select for the execute result stage.
// Ports:
//   i_op     : result op code
//   i_sum    : adder sum (A-B for the set-conditions)
//   i_ovf    : adder signed overflow
//   o_result : SUM for pass ops, zero-extended condition bit otherwise
module ex_setcond
    import ex_pkg::*;
#(
    parameter int N = EX_N
) (
    input  ex_op_e         i_op,
    input  logic [N-1:0]   i_sum,
    input  logic           i_ovf,
    output logic [N-1:0]   o_result
);

    logic w_lt;
    logic w_eq;
    logic w_gt;
    logic w_cond;

    // True sign of A-B: the sum's sign bit is wrong exactly when it overflowed.
    assign w_lt = i_sum[N-1] ^ i_ovf;
    assign w_eq = (i_sum == '0);
    assign w_gt = !w_lt && !w_eq;

    always_comb begin
        w_cond = 1'b0;
        case (i_op)
            OP_SEQ:  w_cond = w_eq;
            OP_SNE:  w_cond = !w_eq;
            OP_SLT:  w_cond = w_lt;
            OP_SGE:  w_cond = !w_lt;
            OP_SGT:  w_cond = w_gt;
            OP_SLE:  w_cond = !w_gt;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        o_result = '0;
        if (i_op == OP_PASS_S || i_op == OP_PASS_U) begin
            o_result = i_sum;
        end else begin
            o_result = {{(N-1){1'b0}}, w_cond};
        end
    end

endmodule

// File: rtl/ex_result_stage.sv
// Execute result stage: turns adder outputs into a registered result with a
// valid/ready handshake toward writeback, and raises a trap on signed
// overflow of a trapping pass op.
// Ports:
//   CLK, RST                     : clock, async active-high reset
//   IN_VALID/IN_READY            : upstream handshake
//   OP, SUM, COUT, OVF, TRAP_EN  : op code, adder outputs, trap enable
//   OUT_VALID/OUT_READY, RESULT  : registered downstream handshake
//   TRAP, TRAP_ACK, FLUSH        : overflow trap flag, its ack, pipeline flush
//
// state   | meaning
// RUN     | normal operation, accepting input when output slot is free
// TRAPPED | overflow trap raised, input blocked until TRAP_ACK or FLUSH
module ex_result_stage
    import ex_pkg::*;
#(
    parameter int N = EX_N
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [2:0]     OP,
    input  logic [N-1:0]   SUM,
    input  logic           COUT,
    input  logic           OVF,
    input  logic           TRAP_EN,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [N-1:0]   RESULT,
    output logic           TRAP,
    input  logic           TRAP_ACK,
    input  logic           FLUSH
);

    ex_state_e    r_state;
    ex_state_e    w_state_nxt;
    logic         r_out_valid;
    logic [N-1:0] r_result;

    ex_op_e       w_op;
    logic [N-1:0] w_sel_result;
    logic         w_accept;
    logic         w_trap_hit;
    logic         w_unused_cout;

    // Carry-out plays no part in any result.
    assign w_unused_cout = COUT;

    assign w_op       = ex_op_e'(OP);
    assign w_accept   = IN_VALID && IN_READY;
    assign w_trap_hit = (w_op == OP_PASS_S) && OVF && TRAP_EN;

    ex_setcond #(.N(N)) u_setcond (
        .i_op     (w_op),
        .i_sum    (SUM),
        .i_ovf    (OVF),
        .o_result (w_sel_result)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (FLUSH) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:     if (w_accept && w_trap_hit) w_state_nxt = ST_TRAPPED;
                ST_TRAPPED: if (TRAP_ACK)               w_state_nxt = ST_RUN;
                default:                                w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_comb begin
        IN_READY = !RST && (r_state == ST_RUN) && !FLUSH && (!r_out_valid || OUT_READY);
        TRAP     = (r_state == ST_TRAPPED);
    end

    // A trapping accept loads nothing; any older result was necessarily
    // being drained in that same cycle, so the valid falls through to the
    // OUT_READY branch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            if (FLUSH) begin
                r_out_valid <= 1'b0;
            end else if (w_accept && !w_trap_hit) begin
                r_out_valid <= 1'b1;
            end else if (OUT_READY) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && !w_trap_hit) begin
                r_result <= w_sel_result;
            end
        end
    end

    assign OUT_VALID = r_out_valid;
    assign RESULT    = r_result;

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;

    localparam logic [2:0] PASS_S = 3'd0, PASS_U = 3'd1, SEQ = 3'd2, SNE = 3'd3,
                           SLT = 3'd4, SGE = 3'd5, SGT = 3'd6, SLE = 3'd7;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID, IN_READY;
    logic [2:0]  OP;
    logic [31:0] SUM;
    logic        COUT, OVF, TRAP_EN;
    logic        OUT_VALID, OUT_READY;
    logic [31:0] RESULT;
    logic        TRAP, TRAP_ACK, FLUSH;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    always #5 CLK = ~CLK;

    ex_result_stage #(.N(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP        (OP),
        .SUM       (SUM),
        .COUT      (COUT),
        .OVF       (OVF),
        .TRAP_EN   (TRAP_EN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .TRAP      (TRAP),
        .TRAP_ACK  (TRAP_ACK),
        .FLUSH     (FLUSH)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: true sign of A-B is sum sign corrected by overflow.
    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] s,
                                              input logic o);
        logic neg, zero;
        neg  = s[31] ^ o;
        zero = (s == 32'd0);
        case (op)
            PASS_S, PASS_U: return s;
            SEQ:            return {31'd0, zero};
            SNE:            return {31'd0, !zero};
            SLT:            return {31'd0, neg};
            SGE:            return {31'd0, !neg};
            SGT:            return {31'd0, !neg && !zero};
            default:        return {31'd0, neg || zero};
        endcase
    endfunction

    function automatic logic model_trap(input logic [2:0] op, input logic o, input logic te);
        return (op == PASS_S) && o && te;
    endfunction

    // Scoreboard: pop/compare on output transfer, push on input acceptance.
    always @(negedge CLK) begin
        if (!RST) begin
            if (OUT_VALID && FLUSH) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end else if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) chk("sb_extra_out", {31'd0, OUT_VALID}, 32'd0);
                else                chk("sb_result", RESULT, sb.pop_front());
            end
            if (IN_VALID && IN_READY && !FLUSH && !model_trap(OP, OVF, TRAP_EN))
                sb.push_back(model_res(OP, SUM, OVF));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [2:0] op, input logic [31:0] s, input logic o,
                          input logic te);
        IN_VALID = 1'b1;
        OP       = op;
        SUM      = s;
        OVF      = o;
        TRAP_EN  = te;
        COUT     = s[0];
    endtask

    // Hold the input until accepted, optionally jittering OUT_READY.
    task automatic send(input logic [2:0] op, input logic [31:0] s, input logic o,
                        input logic rnd_ready);
        set_in(op, s, o, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (rnd_ready) OUT_READY = 1'($urandom_range(0, 1));
            @(negedge CLK);
            if (IN_READY) begin
                step();
                IN_VALID = 1'b0;
                return;
            end
            step();
        end
        chk("send_timeout", {31'd0, IN_READY}, 32'd1);
        IN_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; OP = 3'd0; SUM = 32'd0; COUT = 1'b0; OVF = 1'b0;
        TRAP_EN = 1'b0; OUT_READY = 1'b1; TRAP_ACK = 1'b0; FLUSH = 1'b0;
        #3;
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_trap", {31'd0, TRAP}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        chk("rst_in_ready", {31'd0, IN_READY}, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        #1 chk("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);

        // Signed compare with overflow, then back-to-back set-conditions.
        set_in(SLT, 32'h8000_0000, 1'b1, 1'b0);
        step();
        chk("slt_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("slt_result", RESULT, 32'd0);
        set_in(SEQ, 32'd0, 1'b0, 1'b0);
        step();
        chk("seq_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("seq_result", RESULT, 32'd1);
        set_in(SGT, 32'd5, 1'b0, 1'b0);
        step();
        chk("sgt_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("sgt_result", RESULT, 32'd1);
        IN_VALID = 1'b0;
        step();
        chk("b2b_idle_valid", {31'd0, OUT_VALID}, 32'd0);

        // Backpressure: result held, second input held off.
        set_in(PASS_U, 32'h1234_5678, 1'b0, 1'b0);
        step();
        OUT_READY = 1'b0;
        set_in(PASS_U, 32'hCAFE_0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", {31'd0, OUT_VALID}, 32'd1);
            chk("bp_result", RESULT, 32'h1234_5678);
            chk("bp_in_ready", {31'd0, IN_READY}, 32'd0);
            step();
        end
        OUT_READY = 1'b1;
        #1 chk("bp_release_in_ready", {31'd0, IN_READY}, 32'd1);
        step();
        IN_VALID = 1'b0;
        chk("bp_second_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("bp_second_result", RESULT, 32'hCAFE_0001);
        step();

        // Overflow trap on PASS_S.
        set_in(PASS_S, 32'h7FFF_FFFF, 1'b1, 1'b1);
        step();
        IN_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("trap_flag", {31'd0, TRAP}, 32'd1);
            chk("trap_no_valid", {31'd0, OUT_VALID}, 32'd0);
            chk("trap_in_ready", {31'd0, IN_READY}, 32'd0);
            step();
        end
        chk("trap_result_kept", RESULT, 32'hCAFE_0001);
        TRAP_ACK = 1'b1;
        step();
        TRAP_ACK = 1'b0;
        chk("ack_trap_clear", {31'd0, TRAP}, 32'd0);
        chk("ack_in_ready", {31'd0, IN_READY}, 32'd1);

        // Same operands as PASS_U: passes through, no trap.
        set_in(PASS_U, 32'h7FFF_FFFF, 1'b1, 1'b1);
        step();
        IN_VALID = 1'b0;
        chk("passu_trap", {31'd0, TRAP}, 32'd0);
        chk("passu_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("passu_result", RESULT, 32'h7FFF_FFFF);

        // TRAP_ACK while running has no effect.
        TRAP_ACK = 1'b1;
        step();
        TRAP_ACK = 1'b0;
        chk("run_ack_trap", {31'd0, TRAP}, 32'd0);
        chk("run_ack_in_ready", {31'd0, IN_READY}, 32'd1);

        // Mixed random traffic with jittered OUT_READY.
        for (int i = 0; i < 40; i++)
            send(3'($urandom_range(0, 7)),
                 (i % 5 == 0) ? 32'd0 : $urandom(), 1'($urandom_range(0, 1)), 1'b1);
        OUT_READY = 1'b1;
        repeat (3) step();
        chk("rand_drain", sb.size(), 32'd0);

        // FLUSH with a stalled result and a simultaneous input.
        set_in(PASS_U, 32'h0000_AAAA, 1'b0, 1'b0);
        step();
        OUT_READY = 1'b0;
        set_in(PASS_U, 32'h0000_BBBB, 1'b0, 1'b0);
        FLUSH = 1'b1;
        #1 chk("flush_in_ready", {31'd0, IN_READY}, 32'd0);
        step();
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        chk("flush_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("flush_result", RESULT, 32'h0000_AAAA);
        step();
        chk("flush_no_accept", {31'd0, OUT_VALID}, 32'd0);
        OUT_READY = 1'b1;

        // FLUSH leaves TRAPPED.
        set_in(PASS_S, 32'h8000_0001, 1'b1, 1'b1);
        step();
        IN_VALID = 1'b0;
        chk("flush_trap_set", {31'd0, TRAP}, 32'd1);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        chk("flush_trap_clear", {31'd0, TRAP}, 32'd0);

        // Async reset with a stalled pending result.
        set_in(PASS_U, 32'h0000_1111, 1'b0, 1'b0);
        step();
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("arst_pend_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("arst_pend_result", RESULT, 32'd0);
        chk("arst_pend_in_ready", {31'd0, IN_READY}, 32'd0);
        sb.delete();
        step();
        RST = 1'b0;
        OUT_READY = 1'b1;

        // Async reset while TRAPPED.
        set_in(PASS_S, 32'h7FFF_FFFF, 1'b1, 1'b1);
        step();
        IN_VALID = 1'b0;
        chk("arst_trap_pre", {31'd0, TRAP}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("arst_trap", {31'd0, TRAP}, 32'd0);
        chk("arst_trap_valid", {31'd0, OUT_VALID}, 32'd0);
        step();
        RST = 1'b0;

        // Recovery after reset.
        send(SLE, 32'hFFFF_FFFE, 1'b0, 1'b0);
        chk("recover_result", RESULT, 32'd1);
        repeat (2) step();
        chk("final_drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
